// File: rtl/joy_db9_scan_arbiter_if.sv
// Signal bundle between the joystick scan arbiter, the board pins and the core.
// master: the arbiter side (drives the chain controls, the returned data and the
//         parallel joystick word).
// slave:  the board/core side (drives the chain data, the external master
//         controls and the scan enable).
// Handshake: joy_valid is a one-cycle strobe qualifying joy_word. There is no
// ready/backpressure; the consumer must take the word in the cycle joy_valid is
// high. joy_word holds its value until the next strobe.
interface joy_db9_scan_arbiter_if #(
    parameter int NBITS = 24
);
    logic             scan_en;
    logic             joy_data;
    logic             joy_clk;
    logic             joy_load_n;
    logic             xjoy_clk;
    logic             xjoy_load_n;
    logic             xjoy_data;
    logic [NBITS-1:0] joy_word;
    logic             joy_valid;
    logic             fwd_active;
    logic [2:0]       dbg_state;

    modport master (
        input  scan_en,
        input  joy_data,
        input  xjoy_clk,
        input  xjoy_load_n,
        output joy_clk,
        output joy_load_n,
        output xjoy_data,
        output joy_word,
        output joy_valid,
        output fwd_active,
        output dbg_state
    );

    modport slave (
        output scan_en,
        output joy_data,
        output xjoy_clk,
        output xjoy_load_n,
        input  joy_clk,
        input  joy_load_n,
        input  xjoy_data,
        input  joy_word,
        input  joy_valid,
        input  fwd_active,
        input  dbg_state
    );
endinterface

// File: rtl/joy_db9_scan_arbiter.sv
// DB9/JAMMA joystick shift-register chain sequencer and deserializer.
// Scans a 74HC165-style chain into a parallel active-high joystick word and
// hands the chain pins to an external master only at frame boundaries.
// Optional build macro: JOY_DEBOUNCE_EN -- publish a frame only when it matches
// the previously captured frame.
// dbg_state encoding: 0 IDLE, 1 LOAD, 2 SETTLE, 3 CLK_HI, 4 CLK_LO, 5 DONE, 6 FWD.
module joy_db9_scan_arbiter #(
    parameter int CLK_DIV      = 8,
    parameter int NBITS        = 24,
    parameter int IDLE_TIMEOUT = 4096
) (
    input logic                    CLOCK_50,
    input logic                    RESET,
    joy_db9_scan_arbiter_if.master bus
);

    localparam int IDX_W = (NBITS > 2) ? $clog2(NBITS) : 1;
    localparam int TO_W  = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBITS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_CLK_HI = 3'd3,
        S_CLK_LO = 3'd4,
        S_DONE   = 3'd5,
        S_FWD    = 3'd6
    } state_t;

    state_t             state;
    logic [7:0]         div_cnt;
    logic               tick;
    logic               scanning;
    logic [IDX_W-1:0]   bit_idx;
    logic [NBITS-1:0]   shift_reg;
    logic [NBITS-1:0]   word_q;
    logic               valid_q;
    logic               clk_q;
    logic               load_q;
    logic               fwd_q;
    logic               pending;
    logic [TO_W-1:0]    idle_cnt;

`ifdef JOY_DEBOUNCE_EN
    logic [NBITS-1:0]   prev_q;
`endif

    // Synchronizer stages; the third stage is only a delayed copy for edges.
    logic xclk_s1, xclk_s2, xclk_s3;
    logic xload_s1, xload_s2, xload_s3;
    logic xclk_edge;
    logic xload_edge;
    logic xload_fall;

    // Bring the asynchronous external controls into this clock domain.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            xclk_s1  <= 1'b0;
            xclk_s2  <= 1'b0;
            xclk_s3  <= 1'b0;
            xload_s1 <= 1'b1;
            xload_s2 <= 1'b1;
            xload_s3 <= 1'b1;
        end else begin
            xclk_s1  <= bus.xjoy_clk;
            xclk_s2  <= xclk_s1;
            xclk_s3  <= xclk_s2;
            xload_s1 <= bus.xjoy_load_n;
            xload_s2 <= xload_s1;
            xload_s3 <= xload_s2;
        end
    end

    assign xclk_edge  = xclk_s2 ^ xclk_s3;
    assign xload_edge = xload_s2 ^ xload_s3;
    assign xload_fall = xload_s3 & ~xload_s2;

    // Only the chain-driving states are paced by the tick generator.
    assign scanning = (state == S_LOAD) || (state == S_SETTLE) ||
                      (state == S_CLK_HI) || (state == S_CLK_LO);
    assign tick     = scanning && (div_cnt == DIV_LAST);

    // Tick divider: free-runs during a scan, parked at 0 otherwise so LOAD
    // always starts a fresh tick.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            div_cnt <= 8'd0;
        end else if (scanning) begin
            div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
        end else begin
            div_cnt <= 8'd0;
        end
    end

    // Frame sequencer, external-request latch and forwarding watchdog.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            bit_idx   <= '0;
            shift_reg <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            clk_q     <= 1'b0;
            load_q    <= 1'b1;
            fwd_q     <= 1'b0;
            pending   <= 1'b0;
            idle_cnt  <= '0;
`ifdef JOY_DEBOUNCE_EN
            prev_q    <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            // A load request from the external master is remembered until the
            // current frame finishes.
            if (xload_fall) begin
                pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    clk_q  <= 1'b0;
                    load_q <= 1'b1;
                    if (pending) begin
                        state    <= S_FWD;
                        fwd_q    <= 1'b1;
                        pending  <= 1'b0;
                        idle_cnt <= '0;
                    end else if (bus.scan_en) begin
                        state  <= S_LOAD;
                        load_q <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (tick) begin
                        state  <= S_SETTLE;
                        load_q <= 1'b1;
                        clk_q  <= 1'b0;
                    end
                end

                S_SETTLE: begin
                    // The first bit is already on the chain output after load.
                    if (tick) begin
                        shift_reg <= {shift_reg[NBITS-2:0], ~bus.joy_data};
                        bit_idx   <= IDX_W'(1);
                        clk_q     <= 1'b1;
                        state     <= S_CLK_HI;
                    end
                end

                S_CLK_HI: begin
                    if (tick) begin
                        clk_q <= 1'b0;
                        state <= S_CLK_LO;
                    end
                end

                S_CLK_LO: begin
                    // Sample at the end of the low half, well after the shift.
                    if (tick) begin
                        shift_reg <= {shift_reg[NBITS-2:0], ~bus.joy_data};
                        if (bit_idx == IDX_LAST) begin
                            state <= S_DONE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            clk_q   <= 1'b1;
                            state   <= S_CLK_HI;
                        end
                    end
                end

                S_DONE: begin
`ifdef JOY_DEBOUNCE_EN
                    // Publish only a frame seen twice in a row.
                    if (shift_reg == prev_q) begin
                        word_q  <= shift_reg;
                        valid_q <= 1'b1;
                    end
                    prev_q <= shift_reg;
`else
                    word_q  <= shift_reg;
                    valid_q <= 1'b1;
`endif
                    bit_idx <= '0;
                    state   <= S_IDLE;
                end

                S_FWD: begin
                    // Any activity from the external master keeps the grant.
                    if (xclk_edge || xload_edge) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == TO_LAST) begin
                        idle_cnt <= '0;
                        fwd_q    <= 1'b0;
                        clk_q    <= 1'b0;
                        load_q   <= 1'b1;
                        state    <= S_IDLE;
`ifdef JOY_DEBOUNCE_EN
                        prev_q   <= '0;
`endif
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    fwd_q  <= 1'b0;
                    clk_q  <= 1'b0;
                    load_q <= 1'b1;
                end
            endcase
        end
    end

    // While forwarding, the chain follows the external master pin-for-pin.
    assign bus.joy_clk    = fwd_q ? bus.xjoy_clk    : clk_q;
    assign bus.joy_load_n = fwd_q ? bus.xjoy_load_n : load_q;
    assign bus.xjoy_data  = fwd_q ? bus.joy_data    : 1'b1;
    assign bus.joy_word   = word_q;
    assign bus.joy_valid  = valid_q;
    assign bus.fwd_active = fwd_q;
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_joy_db9_scan_arbiter.sv
// Bench for joy_db9_scan_arbiter: 74HC165 chain model, directed frames,
// external-master forwarding and mid-frame reset.
module tb_joy_db9_scan_arbiter;

    localparam int NB = 24;

    // ---------------- clock / reset ----------------
    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b1;
    int   cyc      = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    joy_db9_scan_arbiter_if #(.NBITS(NB)) bus ();

    joy_db9_scan_arbiter #(
        .CLK_DIV(8),
        .NBITS(NB),
        .IDLE_TIMEOUT(4096)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RESET(RESET),
        .bus(bus.master)
    );

    // ---------------- chain model (74HC165) ----------------
    logic [NB-1:0] par;
    logic [NB-1:0] sr = '1;
    logic          force_en;
    logic          force_val;

    always @(posedge bus.joy_clk or negedge bus.joy_load_n) begin
        if (!bus.joy_load_n) sr <= par;
        else                 sr <= {sr[NB-2:0], 1'b1};
    end

    assign bus.joy_data = force_en ? force_val : sr[NB-1];

    // ---------------- scoreboard ----------------
    logic [NB-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
    endtask

    // Monitor: every joy_valid strobe must match the oldest expected word.
    initial begin : monitor
        logic [NB-1:0] e;
        forever begin
            @(negedge CLOCK_50);
            if (!RESET && bus.joy_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=%0h required=none", bus.joy_word);
                end else begin
                    e = exp_q.pop_front();
                    check("joy_word", 32'(bus.joy_word), 32'(e));
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_valid(input string name, input int bound);
        int n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
        end while (!bus.joy_valid && n < bound);
        if (!bus.joy_valid) timeout_fail(name);
    endtask

`ifdef JOY_DEBOUNCE_EN
    // Present one parallel value to the chain and let one frame load it.
    task automatic frame(input logic [NB-1:0] par_v);
        int n = 0;
        par = par_v;
        while (bus.joy_load_n !== 1'b0 && n < 800) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (bus.joy_load_n !== 1'b0) timeout_fail("frame_load");
        n = 0;
        while (bus.joy_load_n !== 1'b1 && n < 20) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (bus.joy_load_n !== 1'b1) timeout_fail("frame_settle");
    endtask
`endif

    // ---------------- stimulus ----------------
    initial begin : driver
        int n;
        int t0;
        int t1;
        int t2;
        int tv;
        int rises;
        int first_rise;
        int last_rise;
        int bad_period;
        int load_low;
        logic prev_clk;

        bus.scan_en     = 1'b0;
        bus.xjoy_clk    = 1'b0;
        bus.xjoy_load_n = 1'b1;
        par             = '1;
        force_en        = 1'b0;
        force_val       = 1'b1;

        // Reset values
        repeat (3) @(negedge CLOCK_50);
        check("rst_joy_clk",    32'(bus.joy_clk),    32'd0);
        check("rst_joy_load_n", 32'(bus.joy_load_n), 32'd1);
        check("rst_xjoy_data",  32'(bus.xjoy_data),  32'd1);
        check("rst_joy_word",   32'(bus.joy_word),   32'd0);
        check("rst_joy_valid",  32'(bus.joy_valid),  32'd0);
        check("rst_fwd_active", 32'(bus.fwd_active), 32'd0);
        check("rst_state",      32'(bus.dbg_state),  32'd0);

        // Reset asserted during CLK_HI aborts the frame at once
        RESET       = 1'b0;
        par         = 24'h0F0F0F;
        bus.scan_en = 1'b1;
        n = 0;
        while (bus.joy_clk !== 1'b1 && n < 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (bus.joy_clk !== 1'b1) timeout_fail("reach_clk_hi");
        RESET = 1'b1;
        #1;
        check("midrst_joy_clk",    32'(bus.joy_clk),    32'd0);
        check("midrst_joy_load_n", 32'(bus.joy_load_n), 32'd1);
        check("midrst_joy_valid",  32'(bus.joy_valid),  32'd0);
        @(negedge CLOCK_50);
        bus.scan_en = 1'b0;
        RESET       = 1'b0;
        repeat (500) @(negedge CLOCK_50);
        check("midrst_joy_word", 32'(bus.joy_word), 32'd0);

`ifdef JOY_DEBOUNCE_EN
        // A, B, B -> only the second B publishes; A, B, A, B -> nothing
        bus.scan_en = 1'b1;
        frame(24'h0F0F0F);
        frame(24'h3C3C3C);
        exp_q.push_back(24'hC3C3C3);
        frame(24'h3C3C3C);
        frame(24'h0F0F0F);
        frame(24'h3C3C3C);
        frame(24'h0F0F0F);
        frame(24'h3C3C3C);
        bus.scan_en = 1'b0;
        repeat (800) @(negedge CLOCK_50);
        check("dbnc_joy_word", 32'(bus.joy_word), 32'hC3C3C3);
`else
        // Frame 1: only the last-shifted bit low -> 0x000001, with timing
        par = 24'hFFFFFE;
        exp_q.push_back(24'h000001);
        bus.scan_en = 1'b1;
        n = 0;
        while (bus.joy_load_n !== 1'b0 && n < 10) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (bus.joy_load_n !== 1'b0) timeout_fail("frame1_load");
        t0 = cyc;
        load_low = 0;
        while (bus.joy_load_n === 1'b0 && load_low < 50) begin
            load_low++;
            @(negedge CLOCK_50);
        end
        check("load_low_cycles", 32'(load_low), 32'd8);
        rises = 0;
        first_rise = -1;
        last_rise = 0;
        bad_period = 0;
        prev_clk = bus.joy_clk;
        n = 0;
        while (!bus.joy_valid && n < 500) begin
            @(negedge CLOCK_50);
            n++;
            if (bus.joy_clk === 1'b1 && prev_clk === 1'b0) begin
                if (rises == 0) first_rise = cyc - t0;
                else if (cyc - last_rise != 16) bad_period++;
                last_rise = cyc;
                rises++;
            end
            prev_clk = bus.joy_clk;
        end
        if (!bus.joy_valid) timeout_fail("frame1_valid");
        tv = cyc;
        check("clk_rises",        32'(rises),      32'd23);
        check("first_rise_ofs",   32'(first_rise), 32'd16);
        check("clk_period_bad",   32'(bad_period), 32'd0);
        check("valid_latency",    32'(tv - t0),    32'd385);
        t1 = tv;

        // Frame 2: only the first-shifted bit low -> 0x800000
        par = 24'h7FFFFF;
        exp_q.push_back(24'h800000);
        wait_valid("frame2_valid", 500);
        t2 = cyc;
        check("frame_spacing", 32'(t2 - t1), 32'd386);

        // Frame 3 with an external load request arriving around bit 10
        par = 24'h123456;
        exp_q.push_back(24'hEDCBA9);
        repeat (176) @(negedge CLOCK_50);
        bus.xjoy_load_n = 1'b0;
        check("fwd_not_mid_frame", 32'(bus.fwd_active), 32'd0);
        n = 0;
        while (bus.fwd_active !== 1'b1 && n < 600) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (bus.fwd_active !== 1'b1) timeout_fail("fwd_grant");
        check("fwd_word_hold", 32'(bus.joy_word), 32'hEDCBA9);

        // Forwarding: pins follow the external master, data returns to it
        bus.xjoy_load_n = 1'b1;
        #1;
        check("fwd_load_follow", 32'(bus.joy_load_n), 32'd1);
        bus.xjoy_clk = 1'b1;
        #1;
        check("fwd_clk_high", 32'(bus.joy_clk), 32'd1);
        @(negedge CLOCK_50);
        bus.xjoy_clk = 1'b0;
        #1;
        check("fwd_clk_low", 32'(bus.joy_clk), 32'd0);
        force_en  = 1'b1;
        force_val = 1'b0;
        #1;
        check("fwd_xdata_low", 32'(bus.xjoy_data), 32'd0);
        force_val = 1'b1;
        #1;
        check("fwd_xdata_high", 32'(bus.xjoy_data), 32'd1);
        force_en = 1'b0;

        // Static external pins: grant released after the idle timeout
        par = 24'hFFF000;
        n = 0;
        while (bus.fwd_active === 1'b1 && n < 5000) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (bus.fwd_active === 1'b1) timeout_fail("fwd_release");
        check("fwd_timeout_window", 32'(n >= 4096 && n <= 4104), 32'd1);
        check("rel_joy_load_n", 32'(bus.joy_load_n), 32'd1);
        check("rel_xjoy_data",  32'(bus.xjoy_data),  32'd1);
        check("rel_joy_clk",    32'(bus.joy_clk),    32'd0);
        exp_q.push_back(24'h000FFF);
        @(negedge CLOCK_50);
        check("scan_resume", 32'(bus.joy_load_n), 32'd0);
        wait_valid("frame4_valid", 500);
        bus.scan_en = 1'b0;
        repeat (400) @(negedge CLOCK_50);
`endif

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/joy_db9_scan_arbiter.md
Name: joy_db9_scan_arbiter

Overview:
- Sequences the board's 74HC165-style DB9/JAMMA joystick shift-register chain and deserializes it into a parallel joystick word for the core.
- Shares the same chain with an external master (middleboard XJOY_CLK/XJOY_LOAD_N/XJOY_DATA), granting it the pins only at frame boundaries.
- Sits in the board top between the JOY_* pins, the XJOY_* pins and the core's joystick inputs.

Parameters:
- CLK_DIV, 8: CLOCK_50 cycles per tick; one tick is half a JOY_CLK period. Legal range 2..255.
- NBITS, 24: bits per frame (2 joysticks x 12).
- IDLE_TIMEOUT, 4096: cycles without any external edge before the external grant is released.

Ports:
- CLOCK_50  in  1  sole clock.
- RESET  in  1  asynchronous, active-high reset.
- scan_en  in  1  enables the internal scan frames.
- joy_data  in  1  serial data from the chain (active-low buttons).
- joy_clk  out  1  chain shift clock.
- joy_load_n  out  1  chain parallel-load strobe, active low.
- xjoy_clk  in  1  external master clock (async).
- xjoy_load_n  in  1  external master load (async).
- xjoy_data  out  1  chain data returned to the external master.
- joy_word  out  NBITS  last captured frame, active-high; first-shifted bit is at [NBITS-1].
- joy_valid  out  1  one-cycle pulse when joy_word updates.
- fwd_active  out  1  external master currently owns the chain.

Behaviour:
- Reset values: joy_clk=0, joy_load_n=1, xjoy_data=1, joy_word=0, joy_valid=0, fwd_active=0, state IDLE, pending=0, all counters 0.
- Reset mid-frame aborts the frame at once; partial data is discarded.
- xjoy_clk and xjoy_load_n pass through 2-FF synchronizers for edge detection only.
- Any falling edge of synced xjoy_load_n sets pending=1.
- Tick generator: pulses every CLK_DIV cycles while the state is not IDLE or FWD, and restarts at 0 on entry to LOAD.
- IDLE:
  - pending=1 has priority -> FWD.
  - Otherwise scan_en=1 -> LOAD.
- LOAD: joy_load_n=0 for 1 tick -> SETTLE.
- SETTLE: joy_load_n=1, joy_clk=0 for 1 tick; at tick end sample joy_data -> CLK_HI, bit index=1.
- CLK_HI: joy_clk=1 for 1 tick -> CLK_LO.
- CLK_LO: joy_clk=0 for 1 tick; at tick end sample joy_data.
  - If index==NBITS-1 -> DONE.
  - Else index++ and -> CLK_HI.
- Sampling: each sample shifts ~joy_data into a shift register, MSB first.
- DONE (1 cycle): joy_word <= shift register, joy_valid=1 -> IDLE.
- Frame length is 2*NBITS*CLK_DIV + 1 cycles (LOAD through DONE); with defaults, 385.
- pending set mid-frame does not abort the frame; FWD is entered from IDLE after DONE.
- FWD:
  - fwd_active=1.
  - joy_clk and joy_load_n are driven combinationally from raw xjoy_clk and xjoy_load_n.
  - xjoy_data = joy_data.
  - On entry pending is cleared.
  - The idle counter resets on any synced edge of xjoy_clk or xjoy_load_n.
  - When the counter reaches IDLE_TIMEOUT -> IDLE: fwd_active=0, joy_clk=0, joy_load_n=1, xjoy_data=1.
- joy_word holds its value during FWD; joy_valid stays 0.
- The external master's first load pulse, which raised the request, is not forwarded. It must re-issue loads; one lost frame is acceptable.
- Outside FWD, xjoy_data=1 and joy_load_n/joy_clk are registered outputs.
- scan_en dropping mid-frame does not abort the frame; it is checked only in IDLE.

Optional Feature:
- JOY_DEBOUNCE_EN, defined:
  - DONE compares the new frame with the previous captured frame.
  - joy_word updates and joy_valid pulses only when two consecutive frames are identical.
  - The previous-frame register resets to 0 and is cleared on FWD exit.
- Undefined: every frame updates joy_word.

Test Plan:
- Reset, scan_en=1, chain model presents 0xFFFFFE (only the last-shifted bit low), CLK_DIV=8 -> joy_load_n low for 8 cycles; 23 joy_clk pulses of 16-cycle period; joy_word=0x000001; joy_valid pulse 385 cycles after LOAD entry.
- Chain presents 0x7FFFFF -> joy_word=0x800000; successive frames restart without gaps while scan_en=1.
- xjoy_load_n falling mid-frame at bit 10 -> frame completes with correct data; then fwd_active=1; toggling xjoy_clk is seen on joy_clk; joy_data=0 yields xjoy_data=0.
- In FWD, hold xjoy_* static 4096 cycles -> fwd_active=0, joy_load_n=1, xjoy_data=1; scanning resumes next cycle.
- Assert RESET during CLK_HI -> joy_clk=0, joy_load_n=1 immediately; joy_word keeps reset value 0, with no joy_valid.
- JOY_DEBOUNCE_EN: frames A, B, B -> joy_valid only after the third frame, joy_word=B; frames A, B, A, B -> no update.
